// File: rtl/convolution_procesor_rom_sequencer.sv
// Burst read sequencer for a 1-cycle-latency synchronous ROM, streaming words over valid/ready.
// Optional abort (abort_i input, FLUSH state) is compiled in when ROM_SEQ_ABORT_EN is defined.
module convolution_procesor_rom_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  length_i,
`ifdef ROM_SEQ_ABORT_EN
    input  logic                  abort_i,
`endif
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
`ifdef ROM_SEQ_ABORT_EN
    localparam logic [1:0] FLUSH = 2'd3;
`endif

    logic [1:0]            state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issue_cnt;
    logic [LEN_WIDTH-1:0]  pop_cnt;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      fifo_count;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  tag_addr;
    logic                  tag_data;

    logic start_go;
    logic start_zero;
    logic abort_go;
    logic discard;
    logic run_issue;
    logic issue;
    logic push;
    logic pop;
    logic at_last;

`ifdef ROM_SEQ_ABORT_EN
    assign abort_go = abort_i && ((state == RUN) || (state == DRAIN));
    assign discard  = abort_go || (state == FLUSH);
`else
    assign abort_go = 1'b0;
    assign discard  = 1'b0;
`endif

    // The first read issues on the same edge that accepts the command, so the
    // base address is on the ROM bus in the very next cycle.
    assign start_go   = (state == IDLE) && start_i && (length_i != '0);
    assign start_zero = (state == IDLE) && start_i && (length_i == '0);
    assign run_issue  = (state == RUN) && !abort_go && (issue_cnt < len_q)
                        && (outstanding < CNT_W'(FIFO_DEPTH));
    assign issue      = start_go || run_issue;

    assign valid_o = (fifo_count != '0);
    assign data_o  = valid_o ? mem[rd_ptr] : '0;
    assign at_last = (pop_cnt == len_q - LEN_WIDTH'(1));
    assign last_o  = valid_o && at_last;
    assign pop     = valid_o && ready_i;
    assign push    = tag_data && !discard;
    assign busy_o  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            len_q       <= '0;
            issue_cnt   <= '0;
            pop_cnt     <= '0;
            next_addr   <= '0;
            rom_addr_o  <= '0;
            tag_addr    <= 1'b0;
            tag_data    <= 1'b0;
            outstanding <= '0;
            done_o      <= 1'b0;
        end else begin
            done_o   <= start_zero || ((state == DRAIN) && pop && at_last && !abort_go);
            tag_addr <= issue;
            tag_data <= tag_addr;
            if (issue) begin
                rom_addr_o <= start_go ? base_addr_i : next_addr;
                next_addr  <= (start_go ? base_addr_i : next_addr) + ADDR_WIDTH'(1);
                issue_cnt  <= start_go ? LEN_WIDTH'(1) : issue_cnt + LEN_WIDTH'(1);
            end
            if (pop) begin
                pop_cnt <= pop_cnt + LEN_WIDTH'(1);
            end
            // Credits cover every read from issue until its word leaves the FIFO.
            if (abort_go) begin
                outstanding <= '0;
            end else begin
                outstanding <= outstanding + CNT_W'(issue) - CNT_W'(pop);
            end
            case (state)
                IDLE: begin
                    if (start_go) begin
                        state   <= RUN;
                        len_q   <= length_i;
                        pop_cnt <= '0;
                    end
                end
                RUN: begin
`ifdef ROM_SEQ_ABORT_EN
                    if (abort_go) state <= FLUSH;
                    else
`endif
                    if (issue_cnt == len_q) state <= DRAIN;
                end
                DRAIN: begin
`ifdef ROM_SEQ_ABORT_EN
                    if (abort_go) state <= FLUSH;
                    else
`endif
                    if (pop && at_last) state <= IDLE;
                end
`ifdef ROM_SEQ_ABORT_EN
                FLUSH: begin
                    if (!tag_addr && !tag_data) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || discard) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rom_data_i;
    end

    // The credit limit makes a push into a full FIFO without a matching pop impossible.
    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule
